// File: rtl/mem_dp_bytelane_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg : shared types and constants for the mem_dp_bytelane RAM.
//
// Contents
//   state_e     : fill/run controller states (ST_INIT, ST_RUN)
//   lanes()     : number of byte lanes in a DATA_W-bit word
//   MEM_RD_LAT  : read latency in cycles, request edge to response
//
// Build option
//   MEM_OUT_REG_EN : when defined, read responses go through one extra
//                    register stage, so MEM_RD_LAT becomes 2.
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

`ifdef MEM_OUT_REG_EN
  localparam int MEM_RD_LAT = 2;
`else
  localparam int MEM_RD_LAT = 1;
`endif

endpackage

// File: rtl/mem_dp_bytelane_lane.sv
// -----------------------------------------------------------------------------
// mem_lane_dp8 : one 8-bit wide, DEPTH-deep, true-dual-port byte lane.
//
// Ports
//   clk                 : clock shared by both ports
//   we_a_i / we_b_i     : write enable for this lane
//   re_a_i / re_b_i     : read enable; the read register updates only when set
//   addr_a_i / addr_b_i : word address (caller keeps it below DEPTH)
//   din_a_i / din_b_i   : write data
//   dout_a_o / dout_b_o : registered read data, holds between reads
//
// A read at the same address as a write in the same cycle returns the old
// byte. The top is responsible for forwarding and for resolving A/B write
// conflicts; port A is written last here, so it would win regardless.
// -----------------------------------------------------------------------------
module mem_lane_dp8 #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_a_i,
  input  logic              re_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [7:0]        din_a_i,
  output logic [7:0]        dout_a_o,
  input  logic              we_b_i,
  input  logic              re_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [7:0]        din_b_i,
  output logic [7:0]        dout_b_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_a_q;
  logic [7:0] rd_b_q;

  always_ff @(posedge clk) begin
    if (we_b_i) mem_q[addr_b_i] <= din_b_i;
    if (we_a_i) mem_q[addr_a_i] <= din_a_i;
  end

  always_ff @(posedge clk) begin
    if (re_a_i) rd_a_q <= mem_q[addr_a_i];
    if (re_b_i) rd_b_q <= mem_q[addr_b_i];
  end

  assign dout_a_o = rd_a_q;
  assign dout_b_o = rd_b_q;

endmodule

// File: rtl/mem_dp_bytelane.sv
// -----------------------------------------------------------------------------
// mem_dp_bytelane : parametrised true-dual-port RAM with byte-lane writes.
//
// Port A serves the core's instruction/data side, port B the config/DMA
// loader. After reset the whole array is zero-filled (one word per cycle,
// DEPTH cycles) before either port becomes ready.
//
// Ports (x = a or b)
//   clk, rst     : clock; asynchronous active-high reset
//   req_x        : request valid
//   we_x         : per-byte write enables, all zero = read
//   addr_x       : 32-bit word address, only values < DEPTH hit the array
//   dinx         : write data
//   ready_x      : port accepts requests (high once the fill has finished)
//   doutx        : read response data, holds until the next read response
//   rvalid_x     : one-cycle pulse marking a read response
//   oob_x        : one-cycle pulse, accepted request addressed >= DEPTH
//   init_busy    : zero-fill in progress
//
// Build option
//   MEM_OUT_REG_EN : adds an output register on doutx/rvalid_x/oob_x
//                    (read latency 2 instead of 1).
// -----------------------------------------------------------------------------
module mem_dp_bytelane
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8192,
  parameter  int ADDR_W = $clog2(DEPTH),
  localparam int LANES  = lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [LANES-1:0]  we_a,
  input  logic [31:0]       addr_a,
  input  logic [DATA_W-1:0] dina,
  output logic              ready_a,
  output logic [DATA_W-1:0] douta,
  output logic              rvalid_a,
  output logic              oob_a,
  input  logic              req_b,
  input  logic [LANES-1:0]  we_b,
  input  logic [31:0]       addr_b,
  input  logic [DATA_W-1:0] dinb,
  output logic              ready_b,
  output logic [DATA_W-1:0] doutb,
  output logic              rvalid_b,
  output logic              oob_b,
  output logic              init_busy
);

  // ---------------------------------------------------------------------------
  // Zero-fill controller
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: ;
    endcase
  end

  logic fill;
  logic run;
  assign fill      = (state_q == ST_INIT);
  assign run       = (state_q == ST_RUN);
  assign init_busy = fill;
  assign ready_a   = run;
  assign ready_b   = run;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              acc_a, acc_b, in_a, in_b;
  logic              wr_a, wr_b, rd_a, rd_b, same;
  logic [ADDR_W-1:0] idx_a, idx_b;

  assign acc_a = req_a & run;
  assign acc_b = req_b & run;
  // Full-width compare: high address bits must not alias into the array.
  assign in_a  = (addr_a < 32'(DEPTH));
  assign in_b  = (addr_b < 32'(DEPTH));
  assign idx_a = addr_a[ADDR_W-1:0];
  assign idx_b = addr_b[ADDR_W-1:0];
  assign wr_a  = acc_a & in_a & (|we_a);
  assign wr_b  = acc_b & in_b & (|we_b);
  assign rd_a  = acc_a & ~(|we_a);
  assign rd_b  = acc_b & ~(|we_b);
  assign same  = in_a & in_b & (idx_a == idx_b);

  // Lane controls. Port A is borrowed by the fill; B loses any lane that A
  // also writes at the same address.
  logic [LANES-1:0]  lwe_a, lwe_b, a_claim;
  logic [ADDR_W-1:0] laddr_a;
  logic [DATA_W-1:0] ldin_a;

  assign a_claim = (same & wr_a) ? we_a : '0;
  assign lwe_a   = fill ? '1 : (wr_a ? we_a : '0);
  assign lwe_b   = wr_b ? (we_b & ~a_claim) : '0;
  assign laddr_a = fill ? cnt_q : idx_a;
  assign ldin_a  = fill ? '0 : dina;

  logic [DATA_W-1:0] rdat_a, rdat_b;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mem_lane_dp8 #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk      (clk),
      .we_a_i   (lwe_a[i]),
      .re_a_i   (rd_a & in_a),
      .addr_a_i (laddr_a),
      .din_a_i  (ldin_a[8*i +: 8]),
      .dout_a_o (rdat_a[8*i +: 8]),
      .we_b_i   (lwe_b[i]),
      .re_b_i   (rd_b & in_b),
      .addr_b_i (idx_b),
      .din_b_i  (dinb[8*i +: 8]),
      .dout_b_o (rdat_b[8*i +: 8])
    );
  end

  // ---------------------------------------------------------------------------
  // Response state: captured on each accepted read so the merged output
  // holds until the next read. zero_x forces an all-zero response (reset
  // value and out-of-range reads); fmask_x picks lanes forwarded from the
  // other port's same-cycle write.
  // ---------------------------------------------------------------------------
  logic [LANES-1:0]  fmask_a_d, fmask_b_d, fmask_a_q, fmask_b_q;
  logic [DATA_W-1:0] fdat_a_q, fdat_b_q;
  logic              zero_a_q, zero_b_q;
  logic              rvalid_a_q, rvalid_b_q, oob_a_q, oob_b_q;

  assign fmask_a_d = (same & wr_b) ? we_b : '0;
  assign fmask_b_d = (same & wr_a) ? we_a : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      oob_a_q    <= 1'b0;
      oob_b_q    <= 1'b0;
      zero_a_q   <= 1'b1;
      zero_b_q   <= 1'b1;
      fmask_a_q  <= '0;
      fmask_b_q  <= '0;
    end else begin
      rvalid_a_q <= rd_a;
      rvalid_b_q <= rd_b;
      oob_a_q    <= acc_a & ~in_a;
      oob_b_q    <= acc_b & ~in_b;
      if (rd_a) begin
        zero_a_q  <= ~in_a;
        fmask_a_q <= fmask_a_d;
      end
      if (rd_b) begin
        zero_b_q  <= ~in_b;
        fmask_b_q <= fmask_b_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_a) fdat_a_q <= dinb;
    if (rd_b) fdat_b_q <= dina;
  end

  logic [DATA_W-1:0] resp_a, resp_b;

  always_comb begin
    resp_a = '0;
    resp_b = '0;
    for (int i = 0; i < LANES; i++) begin
      resp_a[8*i +: 8] = fmask_a_q[i] ? fdat_a_q[8*i +: 8] : rdat_a[8*i +: 8];
      resp_b[8*i +: 8] = fmask_b_q[i] ? fdat_b_q[8*i +: 8] : rdat_b[8*i +: 8];
    end
    if (zero_a_q) resp_a = '0;
    if (zero_b_q) resp_b = '0;
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef MEM_OUT_REG_EN
  logic [DATA_W-1:0] douta_q, doutb_q;
  logic              rvalid_a_p2, rvalid_b_p2, oob_a_p2, oob_b_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta_q     <= '0;
      doutb_q     <= '0;
      rvalid_a_p2 <= 1'b0;
      rvalid_b_p2 <= 1'b0;
      oob_a_p2    <= 1'b0;
      oob_b_p2    <= 1'b0;
    end else begin
      douta_q     <= resp_a;
      doutb_q     <= resp_b;
      rvalid_a_p2 <= rvalid_a_q;
      rvalid_b_p2 <= rvalid_b_q;
      oob_a_p2    <= oob_a_q;
      oob_b_p2    <= oob_b_q;
    end
  end

  assign douta    = douta_q;
  assign doutb    = doutb_q;
  assign rvalid_a = rvalid_a_p2;
  assign rvalid_b = rvalid_b_p2;
  assign oob_a    = oob_a_p2;
  assign oob_b    = oob_b_p2;
`else
  assign douta    = resp_a;
  assign doutb    = resp_b;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign oob_a    = oob_a_q;
  assign oob_b    = oob_b_q;
`endif

endmodule
